sdram_rd_arb: RTL

//  Round-robin arbiter that merges NCLI read clients (video scanout, CPU

---
 rtl/sdram_rd_arb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sdram_rd_arb.sv
// sdram_rd_arb: round-robin read arbiter for the sdram controller.
// It merges NCLI read clients onto the controller's single read port and
// keeps only one read outstanding at a time. It counts the words that come
// back, and it steers the ack and each data beat to the client that owns the read.
//
// Ports:
//   clk, reset           system clock; synchronous active-high reset
//   cli_req/addr/len     per-client request, word address, burst length code
//   cli_ack, cli_rdy     per-client pulses: request accepted / rd_data_o valid
//   rd_data_o            read data broadcast to all clients
//   rd_req/addr/len      read request to the controller
//   rd_ack, rd_data,     controller accept pulse, data word, data-valid pulse
//   rd_rdy
//   busy                 a read is in flight
//   err                  sticky: unexpected rd_ack/rd_rdy seen
//
// state | meaning
// IDLE  | no read in flight; grant the next requesting client
// REQ   | rd_req raised, waiting for controller rd_ack
// DATA  | read accepted, counting returning words for the owner
module sdram_rd_arb #(
  parameter int NCLI   = 2,
  parameter int XWIDTH = 20,
  parameter int DWIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCLI-1:0]        cli_req,
  input  logic [NCLI*XWIDTH-1:0] cli_addr,
  input  logic [NCLI*4-1:0]      cli_len,
  output logic [NCLI-1:0]        cli_ack,
  output logic [NCLI-1:0]        cli_rdy,
  output logic [DWIDTH-1:0]      rd_data_o,
  output logic                   rd_req,
  output logic [XWIDTH-1:0]      rd_addr,
  output logic [3:0]             rd_len,
  input  logic                   rd_ack,
  input  logic [DWIDTH-1:0]      rd_data,
  input  logic                   rd_rdy,
  output logic                   busy,
  output logic                   err
);

  localparam int IDW = (NCLI > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t            state, state_nxt;
  logic [IDW-1:0]    id, id_nxt;
  logic [IDW-1:0]    last, last_nxt;
  logic [4:0]        cnt, cnt_nxt;
  logic              rd_req_nxt, busy_nxt, err_nxt;
  logic [XWIDTH-1:0] rd_addr_nxt;
  logic [3:0]        rd_len_nxt;
  logic [NCLI-1:0]   cli_ack_nxt, cli_rdy_nxt;
  logic [DWIDTH-1:0] rd_data_nxt;

  logic              found;
  logic [IDW-1:0]    win, idx;
  logic [3:0]        win_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      id        <= '0;
      last      <= IDW'(NCLI - 1);
      cnt       <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      rd_len    <= '0;
      cli_ack   <= '0;
      cli_rdy   <= '0;
      rd_data_o <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      id        <= id_nxt;
      last      <= last_nxt;
      cnt       <= cnt_nxt;
      rd_req    <= rd_req_nxt;
      rd_addr   <= rd_addr_nxt;
      rd_len    <= rd_len_nxt;
      cli_ack   <= cli_ack_nxt;
      cli_rdy   <= cli_rdy_nxt;
      rd_data_o <= rd_data_nxt;
      busy      <= busy_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    // Scan starting one past the last winner so every client gets a turn.
    for (int k = 1; k <= NCLI; k++) begin
      idx = IDW'((int'(last) + k) % NCLI);
      if (!found && cli_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    win_len = cli_len[int'(win)*4 +: 4];
  end

  always_comb begin
    state_nxt   = state;
    id_nxt      = id;
    last_nxt    = last;
    cnt_nxt     = cnt;
    rd_req_nxt  = rd_req;
    rd_addr_nxt = rd_addr;
    rd_len_nxt  = rd_len;
    cli_ack_nxt = '0;
    cli_rdy_nxt = '0;
    rd_data_nxt = rd_data_o;
    busy_nxt    = busy;
    err_nxt     = err;

    case (state)
      IDLE: begin
        if (rd_rdy || rd_ack) err_nxt = 1'b1;
        if (found) begin
          id_nxt      = win;
          last_nxt    = win;
          rd_addr_nxt = cli_addr[int'(win)*XWIDTH +: XWIDTH];
          rd_len_nxt  = win_len;
          // Controller burst rule: code 0 is a single word, otherwise len+2.
          cnt_nxt     = (win_len == 4'd0) ? 5'd1 : {1'b0, win_len} + 5'd2;
          rd_req_nxt  = 1'b1;
          busy_nxt    = 1'b1;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        if (rd_rdy) err_nxt = 1'b1;
        if (rd_ack) begin
          rd_req_nxt      = 1'b0;
          cli_ack_nxt[id] = 1'b1;
          state_nxt       = DATA;
        end
      end
      DATA: begin
        if (rd_ack) err_nxt = 1'b1;
        if (rd_rdy) begin
          cli_rdy_nxt[id] = 1'b1;
          rd_data_nxt     = rd_data;
          cnt_nxt         = cnt - 5'd1;
          if (cnt == 5'd1) begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
